// File: rtl/regs_wb_if.sv
// Execute/LSU/decode/register-file bundle for the regs_wb write-back arbiter.
// i_* are driven toward the arbiter, o_* come back from it.
interface regs_wb_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // Load handshake: a result transfers on any rising clock edge where
    // i_ld_valid and o_ld_ready are both 1; ALU results have no ready and are always taken.
    logic                   i_alu_valid;
    logic [INDEX_WIDTH-1:0] i_alu_index;
    logic [DATA_WIDTH-1:0]  i_alu_data;
    logic                   i_ld_valid;
    logic [INDEX_WIDTH-1:0] i_ld_index;
    logic [DATA_WIDTH-1:0]  i_ld_data;
    logic                   o_ld_ready;
    logic                   i_issue_valid;
    logic [INDEX_WIDTH-1:0] i_issue_index;
    logic [INDEX_WIDTH-1:0] i_chk_index1;
    logic                   o_busy1;
    logic [INDEX_WIDTH-1:0] i_chk_index2;
    logic                   o_busy2;
    logic [INDEX_WIDTH-1:0] o_wr_index;
    logic [DATA_WIDTH-1:0]  o_wr_data;
    logic                   o_wr_enable;
    logic [CW-1:0]          o_fifo_count;

    modport slave (
        input  i_alu_valid, i_alu_index, i_alu_data,
        input  i_ld_valid, i_ld_index, i_ld_data,
        output o_ld_ready,
        input  i_issue_valid, i_issue_index,
        input  i_chk_index1, i_chk_index2,
        output o_busy1, o_busy2,
        output o_wr_index, o_wr_data, o_wr_enable, o_fifo_count
    );

    modport master (
        output i_alu_valid, i_alu_index, i_alu_data,
        output i_ld_valid, i_ld_index, i_ld_data,
        input  o_ld_ready,
        output i_issue_valid, i_issue_index,
        output i_chk_index1, i_chk_index2,
        input  o_busy1, o_busy2,
        input  o_wr_index, o_wr_data, o_wr_enable, o_fifo_count
    );
endinterface

// File: rtl/regs_wb.sv
// Write-back arbiter: ALU results beat buffered load results onto the single register-file
// write port; a pending scoreboard tracks issued loads. Define REGS_WB_BYPASS_EN for load bypass.
module regs_wb #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    regs_wb_if.slave     bus
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << INDEX_WIDTH;

    logic [DATA_WIDTH-1:0]  r_fifo_data  [FIFO_DEPTH];
    logic [INDEX_WIDTH-1:0] r_fifo_index [FIFO_DEPTH];
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;
    logic [NREG-1:0]        r_pending;
    logic                   r_wr_enable;
    logic                   r_wr_from_ld;
    logic [INDEX_WIDTH-1:0] r_wr_index;
    logic [DATA_WIDTH-1:0]  r_wr_data;

    logic                   w_ld_ready;
    logic                   w_ld_accept;
    logic                   w_alu_write;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_bypass;
    logic [NREG-1:0]        w_pending_next;

    // Ready looks only at the registered count; a pop this cycle does not free a slot early.
    assign w_ld_ready  = i_rst & (r_count < CW'(FIFO_DEPTH));
    assign w_ld_accept = bus.i_ld_valid & w_ld_ready;
    assign w_alu_write = bus.i_alu_valid & (bus.i_alu_index != '0);
    assign w_pop       = ~w_alu_write & (r_count != '0);

`ifdef REGS_WB_BYPASS_EN
    assign w_bypass = w_ld_accept & (r_count == '0) & ~bus.i_alu_valid
                      & (bus.i_ld_index != '0);
`else
    assign w_bypass = 1'b0;
`endif

    // Loads to x0 are handshaken but never stored.
    assign w_push = w_ld_accept & (bus.i_ld_index != '0) & ~w_bypass;

    always_comb begin
        w_pending_next = r_pending;
        if (r_wr_enable && r_wr_from_ld) begin
            w_pending_next[r_wr_index] = 1'b0;
        end
        if (bus.i_issue_valid && (bus.i_issue_index != '0)) begin
            w_pending_next[bus.i_issue_index] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr]  <= bus.i_ld_data;
            r_fifo_index[r_wr_ptr] <= bus.i_ld_index;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_pending    <= '0;
            r_wr_enable  <= 1'b0;
            r_wr_from_ld <= 1'b0;
            r_wr_index   <= '0;
            r_wr_data    <= '0;
        end else begin
            r_pending <= w_pending_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_alu_write) begin
                r_wr_enable  <= 1'b1;
                r_wr_from_ld <= 1'b0;
                r_wr_index   <= bus.i_alu_index;
                r_wr_data    <= bus.i_alu_data;
            end else if (w_pop) begin
                r_wr_enable  <= 1'b1;
                r_wr_from_ld <= 1'b1;
                r_wr_index   <= r_fifo_index[r_rd_ptr];
                r_wr_data    <= r_fifo_data[r_rd_ptr];
            end else if (w_bypass) begin
                r_wr_enable  <= 1'b1;
                r_wr_from_ld <= 1'b1;
                r_wr_index   <= bus.i_ld_index;
                r_wr_data    <= bus.i_ld_data;
            end else begin
                r_wr_enable  <= 1'b0;
                r_wr_from_ld <= 1'b0;
            end
        end
    end

    assign bus.o_ld_ready   = w_ld_ready;
    assign bus.o_busy1      = (bus.i_chk_index1 != '0) & r_pending[bus.i_chk_index1];
    assign bus.o_busy2      = (bus.i_chk_index2 != '0) & r_pending[bus.i_chk_index2];
    assign bus.o_wr_index   = r_wr_index;
    assign bus.o_wr_data    = r_wr_data;
    assign bus.o_wr_enable  = r_wr_enable;
    assign bus.o_fifo_count = r_count;
endmodule
